// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter: state encoding, frame
// geometry and the elaboration-time cycles-per-bit calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    // Rounded to nearest so the baud error stays within half a clock per bit.
    function automatic int cpb(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; writes to a full FIFO
// and reads from an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes enter a small FIFO over valid/ready and are
// serialised LSB-first on a registered txd line, back-to-back when queued.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       txd
);

    localparam int CPB   = cpb(CLK_FREQ_HZ, BAUD);
    localparam int CNT_W = (CPB < 2) ? 1 : $clog2(CPB);
    localparam int IDX_W = $clog2(DATA_BITS);

    if (CPB < 2 || FRAME_BITS != DATA_BITS + 2) begin : g_bad_cpb
        $error("uart_tx: cycles per bit must be at least 2");
    end

    state_t                     r_state, w_state_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [DATA_BITS-1:0]       r_shift, w_shift_nxt;
    logic [IDX_W-1:0]           r_idx, w_idx_nxt;
    logic                       r_txd, w_txd_nxt;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_cnt_done;
    logic [7:0]                 w_dout;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .pop   (w_pop),
        .din   (tx_data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign tx_ready   = !w_full;
    assign tx_busy    = (r_state != IDLE) || (w_count != '0);
    assign txd        = r_txd;
    assign w_cnt_done = (r_cnt == CNT_W'(CPB - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_done ? '0 : r_cnt + 1'b1;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_txd_nxt = 1'b1;
                w_cnt_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_dout;
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_cnt_done) begin
                    w_txd_nxt   = r_shift[0];
                    w_idx_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_cnt_done) begin
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_txd_nxt   = r_shift[1];
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                // A queued byte starts its start bit right away: no idle gap.
                if (w_cnt_done) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_dout;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: directed bytes are queued as expectations
// and a line monitor decodes txd frames independently.
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        bit         contig;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_valid_d = 1'b0;
    logic       tx_ready, tx_busy, txd;
    logic       tx_ready_d, tx_busy_d, txd_d;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (250_000),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .txd      (txd)
    );

    uart_tx dut_def (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid_d),
        .tx_ready (tx_ready_d),
        .tx_busy  (tx_busy_d),
        .txd      (txd_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit contig);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        sb.push_back('{data: b, contig: contig});
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Starts sampling at the next negedge, which must be the first start-bit cycle.
    task automatic expect_frame(input logic [7:0] b, input string name);
        logic [9:0] f;
        int errs;
        errs = 0;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (txd !== f[k/4]) errs++;
        end
        chk(name, errs, 0);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (tx_busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", tx_busy, 0);
    endtask

    initial begin : monitor
        logic [39:0] samp;
        logic [7:0]  b;
        bit          in_frame;
        bit          uniform;
        int          n;
        int          idle_cnt;
        exp_t        e;
        in_frame = 0;
        n = 0;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0;
                n = 0;
                idle_cnt = 0;
            end else begin
                if (!in_frame && txd === 1'b0) begin
                    in_frame = 1;
                    n = 0;
                end
                if (!in_frame) begin
                    idle_cnt++;
                end else begin
                    samp[n] = txd;
                    n++;
                    if (n == 40) begin
                        uniform = 1;
                        for (int j = 0; j < 10; j++)
                            for (int k = 1; k < 4; k++)
                                if (samp[4*j+k] !== samp[4*j]) uniform = 0;
                        for (int i = 0; i < 8; i++) b[i] = samp[4*(i+1)];
                        chk("mon_bit_width", uniform, 1);
                        chk("mon_start_stop", {samp[0], samp[36]}, 2'b01);
                        if (sb.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL mon_unexpected_frame: got %0h want none", b);
                        end else begin
                            e = sb.pop_front();
                            chk("mon_data", b, e.data);
                            if (e.contig) chk("mon_gap", idle_cnt, 0);
                        end
                        in_frame = 0;
                        idle_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        int low, len, t;
        #1 rst = 1'b1;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_txd_def", txd_d, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        send(8'h55, 0);
        @(posedge clk);
        expect_frame(8'h55, "wave_55");
        chk("busy_e40", tx_busy, 1);
        @(negedge clk);
        chk("busy_e41", tx_busy, 0);

        // 0x41 pops immediately, 0x42..0x45 fill the FIFO, 0x46 meets ready=0.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_data  = 8'h41 + 8'(i);
            tx_valid = 1'b1;
            if (i == 5) chk("full_ready", tx_ready, 0);
            else sb.push_back('{data: 8'h41 + 8'(i), contig: (i != 0)});
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        wait_idle(400);
        @(negedge clk);
        chk("sb_drained_full", sb.size(), 0);

        send(8'h00, 0);
        send(8'hFF, 1);
        expect_frame(8'h00, "wave_00");
        expect_frame(8'hFF, "wave_ff");
        wait_idle(100);

        send(8'hA5, 0);
        repeat (18) @(posedge clk);
        #2;
        chk("a5_bit3", txd, 0);
        rst = 1'b1;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_ready", tx_ready, 1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(8'hA5, 0);
        @(posedge clk);
        expect_frame(8'hA5, "wave_a5_after_rst");
        wait_idle(100);
        @(negedge clk);
        chk("sb_drained_a5", sb.size(), 0);

        @(negedge clk);
        chk("def_ready", tx_ready_d, 1);
        tx_data    = 8'h01;
        tx_valid_d = 1'b1;
        @(posedge clk);
        #1 tx_valid_d = 1'b0;
        t = 0;
        @(negedge clk);
        while (txd_d !== 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("def_start_seen", txd_d, 0);
        low = 0;
        len = 0;
        while (tx_busy_d && len < 3000) begin
            if (txd_d == 1'b0 && len == low) low++;
            len++;
            @(negedge clk);
        end
        chk("def_start_width", low, 217);
        chk("def_frame_len", len, 2170);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
